// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the Connect Four VGA draw sequencer.
// A block is a 4x4 tile of 2^PIX_W pixels; columns and rows are bounded
// by the board size.
package vga_draw_pkg;

    localparam int PIX_W   = 4;
    localparam int MAX_COL = 6;
    localparam int MAX_ROW = 5;

    // Index of the final pixel of a block; a phase ends when it is reached.
    localparam logic [3:0] BLOCK_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ERASE_PREV = 2'd1,
        DRAW       = 2'd2,
        FLUSH      = 2'd3
    } state_t;

endpackage

// File: rtl/vga_draw_sequencer_counter.sv
// Block pixel counter: walks 0..last while enabled and clears to 0 when idle.
// Because the datapath registers coordinates one cycle after pixel_count,
// plot and erase leave this block one register later than the counter.
module block_pixel_counter #(
    parameter int PIX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             count_en_i,
    input  logic             erase_src_i,
    output logic [PIX_W-1:0] count_o,
    output logic             last_o,
    output logic             plot_o,
    output logic             erase_o
);
    import vga_draw_pkg::*;

    logic [PIX_W-1:0] count_q, count_d;
    logic             plot_q, plot_d;
    logic             erase_q, erase_d;

    // Next count: advance while a phase is active (15 wraps to 0 so the
    // second phase starts cleanly), otherwise park at 0.
    always_comb begin
        count_d = '0;
        plot_d  = count_en_i;
        erase_d = count_en_i & erase_src_i;
        if (count_en_i) begin
            count_d = count_q + PIX_W'(1);
        end
    end

    // Counter plus the one-cycle plot/erase alignment register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            plot_q  <= 1'b0;
            erase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            plot_q  <= plot_d;
            erase_q <= erase_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = count_en_i && (count_q == PIX_W'(BLOCK_LAST));
    assign plot_o  = plot_q;
    assign erase_o = erase_q;

endmodule

// File: rtl/vga_draw_sequencer.sv
// Connect Four VGA draw sequencer.
// Accepts one draw request (preview token or placed piece), optionally
// erases the stale preview token, then sweeps the 16 pixels of the target
// block while driving the coordinate datapath and its plot strobe.
module vga_draw_sequencer #(
    parameter int PIX_W   = vga_draw_pkg::PIX_W,
    parameter int MAX_COL = vga_draw_pkg::MAX_COL,
    parameter int MAX_ROW = vga_draw_pkg::MAX_ROW
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_place,
    input  logic [2:0]       req_location,
    input  logic [2:0]       req_height,
    input  logic             req_player,
    output logic [PIX_W-1:0] pixel_count,
    output logic [2:0]       location,
    output logic [2:0]       decoded_height,
    output logic             go,
    output logic             player,
    output logic             erase,
    output logic             plot,
    output logic             done,
    output logic             err
);
    import vga_draw_pkg::*;

    state_t     state_q, state_d;

    // Request latched at accept; held stable for the whole operation.
    logic       place_q, place_d;
    logic [2:0] loc_q, loc_d;
    logic [2:0] height_q, height_d;
    logic       player_q, player_d;

    // Column of the preview token currently on screen, if any.
    logic       prev_valid_q, prev_valid_d;
    logic [2:0] prev_col_q, prev_col_d;

    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       phase_en;
    logic       erase_src;
    logic       phase_last;
    logic       accept;
    logic       legal;

    // A column beyond the board is never legal; the height only matters
    // for a placed piece since previews always sit on the drop row.
    function automatic logic req_is_legal(input logic       place,
                                          input logic [2:0] loc,
                                          input logic [2:0] height);
        return (int'(loc) <= MAX_COL) && (!place || (int'(height) <= MAX_ROW));
    endfunction

    // The done cycle still counts as busy so a new request cannot land on
    // the same cycle the previous completion is being reported.
    assign req_ready = (state_q == IDLE) && !done_q;
    assign accept    = req_valid && req_ready;
    assign legal     = req_is_legal(req_place, req_location, req_height);
    assign phase_en  = (state_q == ERASE_PREV) || (state_q == DRAW);
    assign erase_src = (state_q == ERASE_PREV);

    block_pixel_counter #(
        .PIX_W (PIX_W)
    ) u_counter (
        .clk         (clk),
        .resetn      (resetn),
        .count_en_i  (phase_en),
        .erase_src_i (erase_src),
        .count_o     (pixel_count),
        .last_o      (phase_last),
        .plot_o      (plot),
        .erase_o     (erase)
    );

    // Next-state logic: accept/reject, phase sequencing, preview bookkeeping.
    always_comb begin
        state_d      = state_q;
        place_d      = place_q;
        loc_d        = loc_q;
        height_d     = height_q;
        player_d     = player_q;
        prev_valid_d = prev_valid_q;
        prev_col_d   = prev_col_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        place_d  = req_place;
                        loc_d    = req_location;
                        height_d = req_place ? req_height : 3'd0;
                        player_d = req_player;
                        // A preview to the column already showing a token is
                        // simply redrawn; anything else must wipe it first.
                        if (prev_valid_q &&
                            (req_place || (req_location != prev_col_q))) begin
                            state_d = ERASE_PREV;
                        end else begin
                            state_d = DRAW;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ERASE_PREV: begin
                if (phase_last) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (phase_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Lets the last delayed plot drain before reporting done.
                state_d = IDLE;
                done_d  = 1'b1;
                if (place_q) begin
                    prev_valid_d = 1'b0;
                end else begin
                    prev_valid_d = 1'b1;
                    prev_col_d   = loc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            place_q      <= 1'b0;
            loc_q        <= 3'd0;
            height_q     <= 3'd0;
            player_q     <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_col_q   <= 3'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            place_q      <= place_d;
            loc_q        <= loc_d;
            height_q     <= height_d;
            player_q     <= player_d;
            prev_valid_q <= prev_valid_d;
            prev_col_q   <= prev_col_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Datapath coordinates: the erase phase targets the old preview on the
    // drop row, every other state presents the latched request.
    always_comb begin
        location       = loc_q;
        go             = place_q;
        decoded_height = height_q;
        player         = player_q;
        if (state_q == ERASE_PREV) begin
            location = prev_col_q;
            go       = 1'b0;
        end
    end

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_vga_draw_sequencer.sv
// Scoreboard bench for vga_draw_sequencer: the driver predicts every plotted
// pixel, done and err pulse with its cycle stamp; a monitor compares them.
module tb_vga_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_place = 1'b0;
    logic [2:0] req_location = 3'd0;
    logic [2:0] req_height = 3'd0;
    logic       req_player = 1'b0;

    logic       req_ready;
    logic [3:0] pixel_count;
    logic [2:0] location;
    logic [2:0] decoded_height;
    logic       go, player, erase, plot, done, err;

    vga_draw_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_place      (req_place),
        .req_location   (req_location),
        .req_height     (req_height),
        .req_player     (req_player),
        .pixel_count    (pixel_count),
        .location       (location),
        .decoded_height (decoded_height),
        .go             (go),
        .player         (player),
        .erase          (erase),
        .plot           (plot),
        .done           (done),
        .err            (err)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pix;
        logic [2:0] loc;
        logic       go;
        logic       erase;
        logic       chk_h;
        logic [2:0] h;
        logic       chk_pl;
        logic       pl;
    } pix_t;

    pix_t pixq[$];
    int   doneq[$];
    int   errq[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Reference model state: which preview token is on screen, busy window.
    bit         m_prev_valid = 1'b0;
    logic [2:0] m_prev_col = 3'd0;
    int         busy_start = 1;
    int         busy_until = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic pix_t mk(int c, int i, logic [2:0] l, logic g, logic e,
                                logic ch, logic [2:0] h, logic cp, logic p);
        pix_t r;
        r.cyc = c; r.pix = 4'(i); r.loc = l; r.go = g; r.erase = e;
        r.chk_h = ch; r.h = h; r.chk_pl = cp; r.pl = p;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request, predicting its full visible response from the rules.
    task automatic send(input logic p, input logic [2:0] l, input logic [2:0] h,
                        input logic pl, input bit poke);
        int  waited = 0;
        int  n0;
        int  nph;
        bit  legal;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
            return;
        end
        req_valid = 1'b1; req_place = p; req_location = l;
        req_height = h; req_player = pl;
        n0 = cyc + 1;
        legal = (l <= 3'd6) && !(p && h > 3'd5);
        if (!legal) begin
            errq.push_back(n0);
        end else begin
            nph = 0;
            if (m_prev_valid && (p || l != m_prev_col)) begin
                for (int i = 0; i < 16; i++)
                    pixq.push_back(mk(n0 + 1 + i, i, m_prev_col, 1'b0, 1'b1,
                                      1'b0, 3'd0, 1'b0, 1'b0));
                nph = 16;
            end
            for (int i = 0; i < 16; i++)
                pixq.push_back(mk(n0 + 1 + nph + i, i, l, p, 1'b0,
                                  p, h, 1'b1, pl));
            doneq.push_back(n0 + nph + 17);
            busy_start = n0;
            busy_until = n0 + nph + 17;
            if (p) m_prev_valid = 1'b0;
            else begin
                m_prev_valid = 1'b1;
                m_prev_col = l;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_location = 3'($urandom_range(0, 6));
        req_player = ~pl;
        if (poke && legal) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            req_valid = 1'b1;
            req_place = ~p;
            req_location = 3'($urandom_range(0, 6));
            req_height = 3'($urandom_range(0, 5));
            req_player = ~pl;
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Monitor: compare every DUT output event against the scoreboard.
    initial begin
        logic [3:0] s_pc = 4'd0;
        logic [2:0] s_loc = 3'd0;
        logic [2:0] s_h = 3'd0;
        logic       s_go = 1'b0;
        logic       s_pl = 1'b0;
        pix_t       e;
        int         ev;
        bit         ok;
        bit         exp_rdy;
        forever begin
            @(posedge clk);
            #1;
            exp_rdy = !(cyc >= busy_start && cyc <= busy_until);
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL req_ready cyc=%0d actual=%b required=%b", cyc, req_ready, exp_rdy);
            end
            if (plot === 1'b1) begin
                checks++;
                if (pixq.size() == 0) begin
                    failures++;
                    $display("FAIL plot_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    e = pixq.pop_front();
                    ok = (cyc == e.cyc) && (s_pc === e.pix) && (s_loc === e.loc) &&
                         (s_go === e.go) && (erase === e.erase) &&
                         (!e.chk_h || s_h === e.h) && (!e.chk_pl || s_pl === e.pl);
                    if (!ok) begin
                        failures++;
                        $display("FAIL pixel actual cyc=%0d pix=%0d loc=%0d go=%b erase=%b h=%0d pl=%b required cyc=%0d pix=%0d loc=%0d go=%b erase=%b h=%0d pl=%b",
                                 cyc, s_pc, s_loc, s_go, erase, s_h, s_pl,
                                 e.cyc, e.pix, e.loc, e.go, e.erase, e.h, e.pl);
                    end
                end
            end else if (erase !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL erase_without_plot cyc=%0d actual=%b required=0", cyc, erase);
            end
            if (done === 1'b1) begin
                checks++;
                if (doneq.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    ev = doneq.pop_front();
                    if (ev != cyc) begin
                        failures++;
                        $display("FAIL done_cycle actual=%0d required=%0d", cyc, ev);
                    end
                end
            end
            if (err === 1'b1) begin
                checks++;
                if (errq.size() == 0) begin
                    failures++;
                    $display("FAIL err_unexpected cyc=%0d actual=1 required=0", cyc);
                end else begin
                    ev = errq.pop_front();
                    if (ev != cyc) begin
                        failures++;
                        $display("FAIL err_cycle actual=%0d required=%0d", cyc, ev);
                    end
                end
            end
            s_pc = pixel_count; s_loc = location; s_go = go;
            s_h = decoded_height; s_pl = player;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, randomized traffic, then a mid-draw reset.
    initial begin
        logic       rp;
        logic [2:0] rl, rh;
        #2;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_plot", 32'(plot), 32'd0);
        chk("reset_erase", 32'(erase), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_pixel_count", 32'(pixel_count), 32'd0);
        chk("reset_location", 32'(location), 32'd0);
        chk("reset_go", 32'(go), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        send(1'b0, 3'd3, 3'd0, 1'b0, 1'b0);
        send(1'b0, 3'd5, 3'd0, 1'b1, 1'b0);
        send(1'b1, 3'd5, 3'd2, 1'b1, 1'b1);
        send(1'b1, 3'd2, 3'd6, 1'b0, 1'b0);
        send(1'b0, 3'd7, 3'd0, 1'b0, 1'b0);
        send(1'b0, 3'd4, 3'd6, 1'b1, 1'b1);
        send(1'b0, 3'd4, 3'd0, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            rp = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) rl = 3'd7;
            else if ($urandom_range(0, 3) == 0) rl = m_prev_col;
            else rl = 3'($urandom_range(0, 6));
            rh = 3'($urandom_range(0, 6));
            send(rp, rl, rh, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Leave a preview on column 1, redraw it, and reset mid-draw.
        send(1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
        send(1'b0, 3'd1, 3'd0, 1'b1, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        resetn = 1'b0;
        pixq.delete();
        doneq.delete();
        busy_start = 1;
        busy_until = 0;
        m_prev_valid = 1'b0;
        #1;
        chk("midreset_plot", 32'(plot), 32'd0);
        chk("midreset_ready", 32'(req_ready), 32'd1);
        chk("midreset_pixel_count", 32'(pixel_count), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        // With no preview remembered this must be a single phase.
        send(1'b0, 3'd6, 3'd0, 1'b1, 1'b0);
        send(1'b1, 3'd6, 3'd0, 1'b0, 1'b0);

        repeat (60) @(negedge clk);
        chk("pending_pixels", 32'(pixq.size()), 32'd0);
        chk("pending_done", 32'(doneq.size()), 32'd0);
        chk("pending_err", 32'(errq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_draw_sequencer.md
Name: vga_draw_sequencer

Overview:
- Controller that sequences the Connect Four VGA coordinate datapath.
- Accepts one draw request at a time from game logic through a valid/ready handshake. A request is either a preview token on the drop row or a placed piece at (column, height).
- Steps the datapath through the 16 pixels of a 4x4 block and generates the plot strobe, aligned to the datapath's one-cycle coordinate register.
- Erases a stale preview token before drawing the new block.

Parameters:
- PIX_W, 4, width of pixel_count; one block is 2^PIX_W = 16 pixels.
- MAX_COL, 6, highest legal column index.
- MAX_ROW, 5, highest legal row (height) index.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle and able to accept.
- req_place  in  1  1 = placed piece, 0 = preview token.
- req_location  in  3  column 0..6.
- req_height  in  3  row 0..5; ignored when req_place = 0.
- req_player  in  1  player 0/1.
- pixel_count  out  4  pixel index to datapath.
- location  out  3  column to datapath.
- decoded_height  out  3  row to datapath.
- go  out  1  to datapath; 1 = piece row, 0 = preview row.
- player  out  1  to datapath colour.
- erase  out  1  forces VGA colour to 000; aligned with plot.
- plot  out  1  VGA write enable.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: asynchronous, active-low, on resetn low. Every output and register goes to 0, except req_ready = 1. State = IDLE; prev_valid = 0.
- Mid-operation reset: plot drops immediately. Pixels already written stay on screen; top level owns any redraw.
- States: IDLE, ERASE_PREV, DRAW, FLUSH.
- IDLE:
  - req_ready = 1.
  - Accept on the edge where req_valid & req_ready. Latch place, location, height and player.
- Rejection at accept:
  - Condition: req_location > MAX_COL, or req_place & req_height > MAX_ROW.
  - Response: err pulses on the next cycle, state stays IDLE, no plot.
- Next state after a legal accept:
  - ERASE_PREV if prev_valid = 1 and the request is a place, or a preview to a different column than prev_col.
  - DRAW otherwise. A preview to the same column redraws it in a single phase.
- ERASE_PREV:
  - location = prev_col, go = 0, erase source = 1.
  - pixel_count runs 0..15, one per cycle, then moves to DRAW with pixel_count wrapping to 0.
- DRAW:
  - Uses the latched request: go = place, erase source = 0.
  - pixel_count runs 0..15, then moves to FLUSH.
- FLUSH: one cycle, then returns to IDLE.
- Plot/erase alignment:
  - The datapath registers coordinates one cycle after pixel_count.
  - plot and erase are therefore the phase-active and erase-source signals delayed by one register.
- Single-phase timing, with accept at edge E0:
  - pixel_count = 0 from E0.
  - plot high E1..E17, 16 cycles.
  - done high E17..E18.
  - req_ready high from E18.
- Two-phase timing: plot is continuous from E1 to E33 and done is high E33..E34. The erase output is high E1..E17.
- Preview tracking:
  - A completed preview sets prev_valid = 1 and prev_col = location.
  - A completed place clears prev_valid.
- Inputs while busy: held latched values are stable. req_valid while req_ready = 0 is ignored, and the requester must hold it.
- Widths: pixel_count wraps 15 -> 0 with no carry out; phase end is detected on pixel_count == 15.

Decomposition:
- Package vga_draw_pkg:
  - State enum.
  - PIX_W, MAX_COL, MAX_ROW.
  - BLOCK_LAST = 4'd15.
- Sub-module block_pixel_counter: 4-bit counter with start/last, plus the one-cycle delayed plot/erase register.

Test Plan:
- Reset, then preview col 3 (no prior preview) -> single phase, 16 plot cycles, erase = 0, go = 0, done at E17, prev_col = 3.
- Preview col 3, then preview col 5 -> 16 erase plots with location 3, then 16 plots with location 5; done at E33.
- Preview col 5, then place col 5 row 2 player 1 -> erase phase at location 5/go 0, then draw phase with go = 1, height 2, player 1; prev_valid cleared.
- Place with req_height = 6, or req_location = 7 -> err pulse, plot never asserts, req_ready stays 1.
- req_valid pulsed during an active draw -> ignored; the in-flight request's location/player are unchanged.
- resetn low at pixel 7 of DRAW -> plot = 0 immediately, state IDLE, prev_valid = 0, req_ready = 1.
